// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and a word-wide data memory.
// Sub-word stores are performed as read-modify-write of the containing word.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, DONE} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;

  logic              req_err;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign mem_re     = (state == RD_ISSUE);
  assign mem_we     = (state == WR);

  // Misaligned or unsupported accesses never reach the memory.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = |req_addr[1:0];
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel  = mem_rdata[{addr_q, 3'b000} +: 8];
    half_sel  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Only the addressed lane is replaced; the rest keeps what memory returned.
  always_comb begin
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00)
      merged[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 2'b00;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= DONE;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_we && req_funct3 == 3'b010) begin
                mem_wdata <= req_wdata;
                state     <= WR;
              end else begin
                state <= RD_ISSUE;
              end
            end
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          if (we_q) begin
            mem_wdata <= merged;
            state     <= WR;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
            state      <= DONE;
          end
        end
        WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed plan steps followed by random
// requests compared against a byte-array reference model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_re;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        pre_we = 1'b0;
  logic [6:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [128];

  logic [7:0]  ref_bytes [512];
  int checks = 0;
  int passes = 0;
  int fails = 0;

  lsu_mem_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory device with a one-cycle read and a preload port.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int widx, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = widx[6:0]; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
    for (int k = 0; k < 4; k++) ref_bytes[widx*4 + k] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_bytes[(a & ~3) + k];
    return w;
  endfunction

  // One transaction: predicts with the model, then watches the DUT until resp_valid.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [8:0] a,
                               input logic [31:0] wd);
    int size, exp_lat, exp_re, exp_we, re_cnt, we_cnt, cyc;
    logic err, done;
    logic [63:0] v;
    logic [31:0] exp_data, exp_word;
    logic [8:0]  wa;
    size = 1 << f3[1:0];
    err = (f3 == 3'd3) || (f3 > 3'd5) || (we && f3[2]) || ((int'(a) % size) != 0);
    wa = {a[8:2], 2'b00};
    exp_data = '0;
    exp_word = '0;
    if (!err && !we) begin
      v = '0;
      for (int k = 0; k < size; k++) v = v + (64'(ref_bytes[int'(a) + k]) << (8*k));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8*size));
      exp_data = v[31:0];
    end
    if (!err && we) begin
      for (int k = 0; k < size; k++) ref_bytes[int'(a) + k] = wd[8*k +: 8];
      exp_word = ref_word(int'(a));
    end
    exp_lat = err ? 1 : (!we ? 3 : (size == 4 ? 2 : 4));
    exp_re  = (!err && (!we || size < 4)) ? 1 : 0;
    exp_we  = (!err && we) ? 1 : 0;

    @(negedge clk);
    checkOutput("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = 9'($urandom); req_wdata = $urandom;
    re_cnt = 0; we_cnt = 0; done = 1'b0; cyc = 0;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      cyc = c;
      if (c == 1) checkOutput("req_ready_busy", {31'b0, req_ready}, 32'd0);
      if (mem_re) begin
        re_cnt++;
        checkOutput("rd_addr", {23'b0, mem_addr}, {23'b0, wa});
        checkOutput("re_we_excl", {31'b0, mem_we}, 32'd0);
      end
      if (mem_we) begin
        we_cnt++;
        checkOutput("wr_addr", {23'b0, mem_addr}, {23'b0, wa});
        checkOutput("wr_data", mem_wdata, exp_word);
      end
      if (resp_valid) done = 1'b1;
    end
    checkOutput("resp_seen", {31'b0, done}, 32'd1);
    checkOutput("latency", cyc, exp_lat);
    checkOutput("resp_rdata", resp_rdata, exp_data);
    checkOutput("resp_err", {31'b0, resp_err}, {31'b0, err});
    checkOutput("re_count", re_cnt, exp_re);
    checkOutput("we_count", we_cnt, exp_we);
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};

    #2;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_mem_re", {31'b0, mem_re}, 32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {23'b0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    for (int i = 0; i < 128; i++) poke(i, $urandom);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed steps from the plan.
    poke(2, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'd2, 9'h008, 32'h0);
    checkOutput("lw_const", resp_rdata, 32'hDEADBEEF);
    poke(2, 32'h80FF1234);
    applyStimulus(1'b0, 3'd0, 9'h00B, 32'h0);
    checkOutput("lb_const", resp_rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'd4, 9'h00B, 32'h0);
    checkOutput("lbu_const", resp_rdata, 32'h00000080);
    applyStimulus(1'b0, 3'd1, 9'h00A, 32'h0);
    checkOutput("lh_const", resp_rdata, 32'hFFFF80FF);
    applyStimulus(1'b0, 3'd5, 9'h00A, 32'h0);
    checkOutput("lhu_const", resp_rdata, 32'h000080FF);
    poke(4, 32'h11223344);
    applyStimulus(1'b1, 3'd0, 9'h011, 32'hFFFFFFAB);
    checkOutput("sb_mem", mem[4], 32'h1122AB44);
    poke(4, 32'h11223344);
    applyStimulus(1'b1, 3'd1, 9'h012, 32'h1234CAFE);
    checkOutput("sh_mem", mem[4], 32'hCAFE3344);
    applyStimulus(1'b1, 3'd2, 9'h1FC, 32'h01020304);
    checkOutput("sw_mem", mem[127], 32'h01020304);
    applyStimulus(1'b0, 3'd2, 9'h006, 32'h0);
    applyStimulus(1'b1, 3'd1, 9'h001, 32'h5555);
    applyStimulus(1'b0, 3'd3, 9'h000, 32'h0);

    // Reset while an SB sits in WR: the write must never land.
    poke(6, 32'hA5A5A5A5);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 9'h019; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_in_wr", {31'b0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_we_drop", {31'b0, mem_we}, 32'd0);
    checkOutput("abort_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("abort_quiet", {31'b0, resp_valid}, 32'd0);
    end
    checkOutput("abort_mem_kept", mem[6], 32'hA5A5A5A5);
    applyStimulus(1'b0, 3'd2, 9'h018, 32'h0);
    checkOutput("after_abort_lw", resp_rdata, 32'hA5A5A5A5);

    // Random requests, biased toward legal funct3 values.
    for (int n = 0; n < 60; n++) begin
      logic [8:0] a;
      a = (n % 10 == 0) ? 9'($urandom_range(508, 511)) : 9'($urandom);
      applyStimulus(1'($urandom), f3_tab[$urandom_range(0, 7)], a, $urandom);
    end
    for (int i = 0; i < 128; i++) checkOutput("final_mem", mem[i], ref_word(i*4));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
